// File: rtl/shift_reg_sequencer_if.sv
// Command channel between a host-side block and the shift register sequencer.
// Valid/ready handshake carrying an opcode, a step count and a data word.
interface shift_reg_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Command-driven controller for a universal shift register: drives MODE/DATAIN
// for load, N-step shifts or N-cycle holds, and pulses done on completion.
module shift_reg_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  shift_reg_sequencer_if.slave cmd,
  output logic [1:0]           sreg_mode,
  output logic [WIDTH-1:0]     sreg_din,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_SHR   = 2'b01,
    OP_SHL   = 2'b10,
    OP_LOAD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [IDX_W-1:0] idx_next;
  op_e              cmd_op_e;

  assign cmd_op_e = op_e'(cmd.cmd_op);
  assign idx_next = (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + 1'b1;

  // Every output is computed for the *next* state and registered, so nothing
  // combinational reaches the pins from the command inputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mode_d  = OP_HOLD;
    din_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          op_d   = cmd_op_e;
          data_d = cmd.cmd_data;
          idx_d  = '0;
          if (cmd_op_e == OP_LOAD) begin
            state_d = S_LOAD;
            mode_d  = OP_LOAD;
            din_d   = cmd.cmd_data;
          end else if (cmd.cmd_count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            cnt_d   = cmd.cmd_count;
            mode_d  = cmd_op_e;
            // First RUN cycle presents bit 0; the index then points at bit 1.
            if (cmd_op_e != OP_HOLD) din_d = WIDTH'(cmd.cmd_data[0]);
            idx_d   = (WIDTH > 1) ? IDX_W'(1) : '0;
          end
        end
      end
      S_LOAD: begin
        state_d = S_DONE;
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          mode_d = op_q;
          if (op_q != OP_HOLD) din_d = WIDTH'(data_q[idx_q]);
          idx_d  = idx_next;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_HOLD;
      data_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      mode_q  <= OP_HOLD;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign sreg_mode     = mode_q;
  assign sreg_din      = din_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Self-checking bench for shift_reg_sequencer: directed scenarios plus random
// commands, checked per cycle against a command-level reference model.
module tb_shift_reg_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clock;
  logic             rst_n;
  logic [1:0]       sreg_mode;
  logic [WIDTH-1:0] sreg_din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] exp_reg;

  int n_checks = 0;
  int n_errors = 0;

  shift_reg_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

  shift_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (rst_n),
    .cmd       (cmd_if.slave),
    .sreg_mode (sreg_mode),
    .sreg_din  (sreg_din),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The universal shift register the sequencer is steering.
  always @(posedge clock) begin
    case (sreg_mode)
      2'b01:   sreg <= {sreg_din[0], sreg[WIDTH-1:1]};
      2'b10:   sreg <= {sreg[WIDTH-2:0], sreg_din[0]};
      2'b11:   sreg <= sreg_din;
      default: sreg <= sreg;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Final register contents after a whole command, from the command's meaning.
  function automatic logic [WIDTH-1:0] ref_apply(input logic [WIDTH-1:0] start,
      input logic [1:0] op, input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] data);
    logic [WIDTH-1:0] r;
    logic             b;
    r = start;
    if (op == 2'b11) return data;
    for (int k = 0; k < int'(cnt); k++) begin
      b = data[k % WIDTH];
      if (op == 2'b01) r = {b, r[WIDTH-1:1]};
      else if (op == 2'b10) r = {r[WIDTH-2:0], b};
    end
    return r;
  endfunction

  // Called at a negedge while the sequencer is idle; returns at the negedge of
  // the idle cycle following done.
  task automatic run_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                         input logic [WIDTH-1:0] data, input bit keep_valid);
    int               waited;
    int               total;
    logic [1:0]       emode;
    logic [WIDTH-1:0] edin;
    logic             edone;
    logic [WIDTH-1:0] exp_new;

    exp_new            = ref_apply(exp_reg, op, cnt, data);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_op      = op;
    cmd_if.cmd_count   = cnt;
    cmd_if.cmd_data    = data;
    waited = 0;
    while (cmd_if.cmd_ready !== 1'b1 && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    check("accept_wait", waited, 0);
    @(posedge clock);

    total = (op == 2'b11) ? 1 : int'(cnt);
    for (int c = 0; c <= total; c++) begin
      @(negedge clock);
      if (c < total) begin
        emode = op;
        edone = 1'b0;
        if (op == 2'b11)      edin = data;
        else if (op == 2'b00) edin = '0;
        else                  edin = WIDTH'(data[c % WIDTH]);
      end else begin
        emode = 2'b00;
        edin  = '0;
        edone = 1'b1;
      end
      check("mode", sreg_mode, emode);
      check("din", sreg_din, edin);
      check("done", done, edone);
      check("busy", busy, 1'b1);
      check("ready_busy", cmd_if.cmd_ready, 1'b0);
      // Garbage on the command bus while busy must be ignored.
      cmd_if.cmd_op    = 2'($urandom);
      cmd_if.cmd_count = CNT_W'($urandom);
      cmd_if.cmd_data  = WIDTH'($urandom);
      cmd_if.cmd_valid = (c == total) ? keep_valid : 1'($urandom_range(0, 1));
    end
    check("final_reg", sreg, exp_new);
    exp_reg = exp_new;

    @(negedge clock);
    check("idle_ready", cmd_if.cmd_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_mode", sreg_mode, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_done;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;

    rst_n            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_count = '0;
    cmd_if.cmd_data  = '0;
    exp_reg          = '0;

    repeat (3) @(negedge clock);
    check("rst_mode", sreg_mode, 2'b00);
    check("rst_din", sreg_din, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", cmd_if.cmd_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clock);
    check("ready_after_rst", cmd_if.cmd_ready, 1'b1);

    run_cmd(2'b11, 4'd0, 4'b1011, 1'b0);
    check("tp_load", sreg, 4'b1011);
    run_cmd(2'b11, 4'd0, 4'b0000, 1'b0);
    run_cmd(2'b01, 4'd3, 4'b0101, 1'b0);
    check("tp_shr3", sreg, 4'b1010);
    run_cmd(2'b11, 4'd0, 4'b1111, 1'b0);
    run_cmd(2'b10, 4'd6, 4'b0010, 1'b0);
    check("tp_shl6", sreg, 4'b0001);
    run_cmd(2'b00, 4'd0, 4'b1010, 1'b0);
    run_cmd(2'b01, 4'd0, 4'b1010, 1'b0);
    check("tp_cnt0", sreg, 4'b0001);
    run_cmd(2'b00, 4'd15, 4'b1111, 1'b0);
    run_cmd(2'b10, 4'd15, 4'b0110, 1'b0);

    // Reset in the middle of a 10-step shift.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b01;
    cmd_if.cmd_count = 4'd10;
    cmd_if.cmd_data  = 4'b1001;
    @(posedge clock);
    @(negedge clock);
    cmd_if.cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_run_mode", sreg_mode, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mode", sreg_mode, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ready", cmd_if.cmd_ready, 1'b0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clock);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 1'b0);
    check("abort_idle_ready", cmd_if.cmd_ready, 1'b1);
    run_cmd(2'b11, 4'd0, 4'b0110, 1'b0);
    check("post_abort_load", sreg, 4'b0110);

    // Random commands, often with cmd_valid held high between them.
    for (int i = 0; i < 60; i++) begin
      r_op = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       r_cnt = '0;
        1:       r_cnt = '1;
        default: r_cnt = CNT_W'($urandom);
      endcase
      run_cmd(r_op, r_cnt, WIDTH'($urandom), (i != 59) && ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
